// File: rtl/i2s_slave_rx_if.sv
// Word-delivery bus of the I2S slave receiver: received sample, channel tag,
// valid/ready handshake and the two error pulses.
interface i2s_slave_rx_if #(
    parameter int DAT_WIDTH = 32
);
    logic [DAT_WIDTH-1:0] dat_o;
    logic                 chn_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 ovf_o;
    logic                 frm_err_o;

    modport master (
        output dat_o,
        output chn_o,
        output valid_o,
        output ovf_o,
        output frm_err_o,
        input  ready_i
    );

    modport slave (
        input  dat_o,
        input  chn_o,
        input  valid_o,
        input  ovf_o,
        input  frm_err_o,
        output ready_i
    );
endinterface

// File: rtl/i2s_slave_rx.sv
// I2S slave-mode receiver: synchronises external SCK/WS/SD, deserialises
// Philips-format MSB-first words and offers them on a valid/ready holding register.
module i2s_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DAT_WIDTH   = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           pol_i,
    input  logic [1:0]     chm_i,
    input  logic [1:0]     chl_i,
    input  logic           sck_i,
    input  logic           ws_i,
    input  logic           sd_i,
    i2s_slave_rx_if.master bus
);
    localparam int CW = $clog2(DAT_WIDTH + 1);

    localparam logic [1:0] CHM_STEREO = 2'd0;
    localparam logic [1:0] CHM_LEFT   = 2'd1;
    localparam logic [1:0] CHM_RIGHT  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SHIFT,
        DONE,
        WAIT
    } state_t;

    // Stage SYNC_STAGES is the extra edge-detect flop; all three pins share the chain.
    genvar gi;
    for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] stage_q;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_i) begin
                if (rst_i) stage_q <= '0;
                else       stage_q <= {sck_i, ws_i, sd_i};
            end
        end else begin : g_next
            always_ff @(posedge clk_i) begin
                if (rst_i) stage_q <= '0;
                else       stage_q <= g_sync[gi-1].stage_q;
            end
        end
    end

    logic sck_new;
    logic sck_old;
    logic ws_s;
    logic sd_s;
    logic strobe;

    assign sck_new = g_sync[SYNC_STAGES-1].stage_q[2];
    assign sck_old = g_sync[SYNC_STAGES].stage_q[2];
    assign ws_s    = g_sync[SYNC_STAGES].stage_q[1];
    assign sd_s    = g_sync[SYNC_STAGES].stage_q[0];
    assign strobe  = pol_i ? (sck_old & ~sck_new) : (sck_new & ~sck_old);

    function automatic logic [CW-1:0] word_len(input logic [1:0] chl);
        int n;
        n = (int'(chl) + 1) * 8;
        if (n > DAT_WIDTH) n = DAT_WIDTH;
        return CW'(n);
    endfunction

    state_t               state_q, state_d;
    logic                 ws_last_q, ws_last_d;
    logic                 ws_seen_q, ws_seen_d;
    logic [DAT_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 chn_q, chn_d;
    logic [1:0]           chm_q, chm_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 chn_out_q, chn_out_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 frm_q, frm_d;

    logic ws_chg;
    logic accept;
    logic start_word;

    // ws_seen_q blocks a bogus "change" against a stale ws after reset or re-enable.
    assign ws_chg = strobe & ws_seen_q & (ws_s != ws_last_q);
    assign accept = (chm_q == CHM_STEREO) ||
                    ((chm_q == CHM_LEFT)  && !chn_q) ||
                    ((chm_q == CHM_RIGHT) &&  chn_q);

    always_comb begin
        state_d    = state_q;
        ws_last_d  = strobe ? ws_s : ws_last_q;
        ws_seen_d  = (state_q == IDLE) ? 1'b0 : (ws_seen_q | strobe);
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        chn_d      = chn_q;
        chm_d      = chm_q;
        dat_d      = dat_q;
        chn_out_d  = chn_out_q;
        valid_d    = valid_q & ~bus.ready_i;
        ovf_d      = 1'b0;
        frm_d      = 1'b0;
        start_word = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) state_d = SYNC;
            end
            SYNC: begin
                if (ws_chg) start_word = 1'b1;
            end
            SHIFT: begin
                // The edge revealing the ws change carries the previous slot's
                // last bit, so shifting begins on the following edge.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (ws_chg) begin
                    frm_d      = 1'b1;
                    start_word = 1'b1;
                end else if (strobe) begin
                    shift_d = {shift_q[DAT_WIDTH-2:0], sd_s};
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = WAIT;
                if (accept) begin
                    if (!valid_q || bus.ready_i) begin
                        dat_d     = shift_q;
                        chn_out_d = chn_q;
                        valid_d   = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (ws_chg) start_word = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_word) begin
            chm_d   = chm_i;
            chn_d   = ws_s;
            shift_d = '0;
            cnt_d   = word_len(chl_i);
            state_d = SHIFT;
        end

        if (!en_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            frm_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ws_last_q <= 1'b0;
            ws_seen_q <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            chn_q     <= 1'b0;
            chm_q     <= 2'd0;
            dat_q     <= '0;
            chn_out_q <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            frm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ws_last_q <= ws_last_d;
            ws_seen_q <= ws_seen_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            chn_q     <= chn_d;
            chm_q     <= chm_d;
            dat_q     <= dat_d;
            chn_out_q <= chn_out_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            frm_q     <= frm_d;
        end
    end

    assign bus.dat_o     = dat_q;
    assign bus.chn_o     = chn_out_q;
    assign bus.valid_o   = valid_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.frm_err_o = frm_q;
endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: acts as an I2S master transmitter and
// checks delivered words, latency and error pulses against hand-computed values.
module tb_i2s_slave_rx;
    localparam int SS  = 2;
    localparam int LAT = SS + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pol = 1'b0;
    logic [1:0] chm = 2'd0;
    logic [1:0] chl = 2'd1;
    logic       sck = 1'b0;
    logic       ws  = 1'b1;
    logic       sd  = 1'b0;

    i2s_slave_rx_if #(.DAT_WIDTH(32)) bus ();

    i2s_slave_rx #(.SYNC_STAGES(SS), .DAT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .pol_i (pol),
        .chm_i (chm),
        .chl_i (chl),
        .sck_i (sck),
        .ws_i  (ws),
        .sd_i  (sd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        chn;
        int          lat;
    } word_t;

    word_t rx_q[$];
    int    cyc     = 0;
    int    lsb_cyc = 0;
    int    ovf_cnt = 0;
    int    frm_cnt = 0;
    logic  v_prev  = 1'b0;
    logic  rdy_neg = 1'b0;
    int    checks  = 0;
    int    errors  = 0;

    always @(negedge clk) begin
        #1;
        rdy_neg = bus.ready_i;
    end

    always @(posedge clk) begin
        word_t w;
        cyc = cyc + 1;
        #1;
        if (bus.valid_o && (!v_prev || rdy_neg)) begin
            w.dat = bus.dat_o;
            w.chn = bus.chn_o;
            w.lat = cyc - lsb_cyc;
            rx_q.push_back(w);
            $display("rx word dat=%08h chn=%0d latency=%0d", w.dat, w.chn, w.lat);
        end
        if (bus.ovf_o)     ovf_cnt = ovf_cnt + 1;
        if (bus.frm_err_o) frm_cnt = frm_cnt + 1;
        v_prev = bus.valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One SCK period: data changes on the non-sampling edge, then the sampling edge.
    task automatic tx_bit(input logic w, input logic d, input bit mark);
        sck = pol;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = ~pol;
        if (mark) lsb_cyc = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_word(input logic c, input logic [31:0] data, input int n,
                           input int slot, input logic junk);
        tx_bit(c, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tx_bit(c, data[n-1-i], (i == n - 1));
        for (int i = n + 1; i < slot; i++) tx_bit(c, junk, 1'b0);
    endtask

    initial begin
        int          b_ovf;
        int          b_frm;
        logic [15:0] part;

        bus.ready_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_dat",   bus.dat_o,     32'h0);
        chk("rst_chn",   32'(bus.chn_o),     32'h0);
        chk("rst_valid", 32'(bus.valid_o),   32'h0);
        chk("rst_ovf",   32'(bus.ovf_o),     32'h0);
        chk("rst_frm",   32'(bus.frm_err_o), 32'h0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // Stereo 16-bit, rising-edge sampling.
        b_ovf = ovf_cnt; b_frm = frm_cnt; rx_q.delete();
        pol = 1'b0; chm = 2'd0; chl = 2'd1;
        repeat (3) tx_bit(1'b1, 1'b0, 1'b0);
        tx_word(1'b0, 32'h0000A5C3, 16, 32, 1'b0);
        tx_word(1'b1, 32'h00001234, 16, 32, 1'b1);
        chk("st_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("st_l_dat", rx_q[0].dat, 32'h0000A5C3);
            chk("st_l_chn", 32'(rx_q[0].chn), 32'd0);
            chk("st_l_lat", 32'(rx_q[0].lat), 32'(LAT));
            chk("st_r_dat", rx_q[1].dat, 32'h00001234);
            chk("st_r_chn", 32'(rx_q[1].chn), 32'd1);
            chk("st_r_lat", 32'(rx_q[1].lat), 32'(LAT));
        end
        chk("st_frm", 32'(frm_cnt - b_frm), 32'd0);
        chk("st_ovf", 32'(ovf_cnt - b_ovf), 32'd0);

        // 8-bit word in a long slot, falling-edge sampling, junk afterwards.
        b_frm = frm_cnt; rx_q.delete();
        pol = 1'b1; chl = 2'd0;
        tx_word(1'b0, 32'h00000081, 8, 33, 1'b1);
        chk("b8_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            chk("b8_dat", rx_q[0].dat, 32'h00000081);
            chk("b8_chn", 32'(rx_q[0].chn), 32'd0);
            chk("b8_lat", 32'(rx_q[0].lat), 32'(LAT));
        end
        chk("b8_frm", 32'(frm_cnt - b_frm), 32'd0);

        // Right-only 24-bit: a NONE filler slot first so left starts on a ws change.
        b_ovf = ovf_cnt; rx_q.delete();
        chm = 2'd3; chl = 2'd0;
        tx_word(1'b1, 32'h000000FF, 8, 32, 1'b0);
        chm = 2'd2; chl = 2'd2;
        tx_word(1'b0, 32'h00FFFFFF, 24, 32, 1'b1);
        tx_word(1'b1, 32'h0000ABCD, 24, 32, 1'b0);
        chk("rt_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            chk("rt_dat", rx_q[0].dat, 32'h0000ABCD);
            chk("rt_chn", 32'(rx_q[0].chn), 32'd1);
        end
        chk("rt_ovf", 32'(ovf_cnt - b_ovf), 32'd0);

        // Overflow: consumer stalled across two completed words.
        b_ovf = ovf_cnt; rx_q.delete();
        chm = 2'd0; chl = 2'd1;
        bus.ready_i = 1'b0;
        tx_word(1'b0, 32'h00001111, 16, 32, 1'b0);
        tx_word(1'b1, 32'h00002222, 16, 32, 1'b0);
        chk("ov_count", 32'(rx_q.size()), 32'd1);
        chk("ov_pulses", 32'(ovf_cnt - b_ovf), 32'd1);
        chk("ov_valid", 32'(bus.valid_o), 32'd1);
        chk("ov_dat", bus.dat_o, 32'h00001111);
        chk("ov_chn", 32'(bus.chn_o), 32'd0);
        bus.ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("ov_drain", 32'(bus.valid_o), 32'd0);

        // Early ws change after 10 of 16 bits.
        b_frm = frm_cnt; rx_q.delete();
        part = 16'hBEEF;
        tx_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tx_bit(1'b0, part[15-i], 1'b0);
        tx_word(1'b1, 32'h00005A5A, 16, 32, 1'b0);
        chk("fe_pulses", 32'(frm_cnt - b_frm), 32'd1);
        chk("fe_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            chk("fe_dat", rx_q[0].dat, 32'h00005A5A);
            chk("fe_chn", 32'(rx_q[0].chn), 32'd1);
        end

        // Disable mid-word while a word is held, then resync and reset mid-frame.
        b_ovf = ovf_cnt; b_frm = frm_cnt; rx_q.delete();
        bus.ready_i = 1'b0;
        tx_word(1'b0, 32'h00007777, 16, 32, 1'b0);
        tx_bit(1'b1, 1'b0, 1'b0);
        repeat (5) tx_bit(1'b1, 1'b1, 1'b0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_valid", 32'(bus.valid_o), 32'd0);
        chk("en_dat", bus.dat_o, 32'h00007777);
        chk("en_ovf", 32'(ovf_cnt - b_ovf), 32'd0);
        chk("en_frm", 32'(frm_cnt - b_frm), 32'd0);
        bus.ready_i = 1'b1;
        en = 1'b1;
        repeat (4) tx_bit(1'b1, 1'b0, 1'b0);
        chk("en_quiet", 32'(rx_q.size()), 32'd1);
        tx_word(1'b0, 32'h00000F0F, 16, 32, 1'b0);
        chk("en_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("en_dat2", rx_q[1].dat, 32'h00000F0F);
            chk("en_chn2", 32'(rx_q[1].chn), 32'd0);
        end
        tx_bit(1'b1, 1'b0, 1'b0);
        repeat (3) tx_bit(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("pr_dat",   bus.dat_o,     32'h0);
        chk("pr_chn",   32'(bus.chn_o),     32'h0);
        chk("pr_valid", 32'(bus.valid_o),   32'h0);
        chk("pr_ovf",   32'(bus.ovf_o),     32'h0);
        chk("pr_frm",   32'(bus.frm_err_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
